// File: rtl/dpram_dma.sv
// dpram_dma - fill/copy engine driving one port of a dual-port RAM.
//
// Software loads the job inputs, pulses start, then polls busy or waits for
// done. A fill writes fill_value to length consecutive words starting at
// dst_address. A copy moves length words from src_address to dst_address,
// taking three cycles per word: RD (present source address), WAIT (the RAM's
// registered q becomes valid and is captured) and WR (write to destination).
// All address arithmetic wraps modulo 2**address_width.
//
// Optional build macro: DPRAM_DMA_OVERLAP_SAFE_EN
//   When defined, a copy whose destination lies inside (src, src+length)
//   runs in descending word order, so the result matches a memmove.
//   When undefined, copies are always ascending, and such overlaps replicate
//   the leading words (used deliberately for pattern fills).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, mode         job request (sampled in IDLE only), 0=fill 1=copy
//   src_address         copy source base
//   dst_address         destination base
//   length              word count, 0..2**address_width
//   fill_value          word written by a fill
//   busy, done          job in progress / one-cycle completion pulse
//   ram_address, ram_wren, ram_data   registered RAM port drive
//   ram_q               RAM registered read data (one-cycle latency)
module dpram_dma #(
    parameter int address_width = 10,
    parameter int data_width    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [address_width-1:0] src_address,
    input  logic [address_width-1:0] dst_address,
    input  logic [address_width:0]   length,
    input  logic [data_width-1:0]    fill_value,
    output logic                     busy,
    output logic                     done,
    output logic [address_width-1:0] ram_address,
    output logic                     ram_wren,
    output logic [data_width-1:0]    ram_data,
    input  logic [data_width-1:0]    ram_q
);

    typedef enum logic [2:0] {IDLE, FILL, RD, WAIT, WR, FIN} state_t;

    state_t                   state_reg, state_next;
    logic [address_width:0]   cnt_reg, cnt_next;     // words completed
    logic [address_width-1:0] off_reg, off_next;     // current word offset i
    logic [address_width-1:0] src_reg, src_next;
    logic [address_width-1:0] dst_reg, dst_next;
    logic [address_width:0]   len_reg, len_next;
    logic                     desc_reg, desc_next;   // descending word order
    logic                     busy_reg, busy_next;
    logic                     done_reg, done_next;
    logic [address_width-1:0] addr_reg, addr_next;
    logic                     wren_reg, wren_next;
    logic [data_width-1:0]    data_reg, data_next;

    logic                     desc_start;
    logic [address_width-1:0] off_start;
    logic [address_width:0]   cnt_inc;
    logic                     last_word;
    logic [address_width-1:0] off_step;

`ifdef DPRAM_DMA_OVERLAP_SAFE_EN
    logic [address_width-1:0] gap;
    // Destination strictly inside the source window: ascending order would
    // overwrite source words before they are read, so walk from the top.
    always_comb begin
        gap        = dst_address - src_address;
        desc_start = mode && (gap != '0) && ({1'b0, gap} < length);
    end
`else
    assign desc_start = 1'b0;
`endif

    assign off_start = desc_start ? (length[address_width-1:0] - 1'b1) : '0;
    assign cnt_inc   = cnt_reg + 1'b1;
    assign last_word = (cnt_inc == len_reg);
    assign off_step  = desc_reg ? (off_reg - 1'b1) : (off_reg + 1'b1);

    // Output registers are loaded with the values belonging to the state
    // being entered, so every output is a flop yet matches its state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        off_next   = off_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        len_next   = len_reg;
        desc_next  = desc_reg;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        addr_next  = addr_reg;
        wren_next  = 1'b0;
        data_next  = data_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    src_next  = src_address;
                    dst_next  = dst_address;
                    len_next  = length;
                    desc_next = desc_start;
                    cnt_next  = '0;
                    off_next  = off_start;
                    if (length == '0) begin
                        state_next = FIN;
                        done_next  = 1'b1;
                    end else if (!mode) begin
                        state_next = FILL;
                        busy_next  = 1'b1;
                        wren_next  = 1'b1;
                        addr_next  = dst_address;
                        data_next  = fill_value;
                    end else begin
                        state_next = RD;
                        busy_next  = 1'b1;
                        addr_next  = src_address + off_start;
                    end
                end
            end
            FILL: begin
                if (last_word) begin
                    state_next = FIN;
                    done_next  = 1'b1;
                end else begin
                    cnt_next  = cnt_inc;
                    off_next  = off_step;
                    busy_next = 1'b1;
                    wren_next = 1'b1;
                    addr_next = dst_reg + off_step;
                end
            end
            RD: begin
                state_next = WAIT;
                busy_next  = 1'b1;
            end
            WAIT: begin
                // ram_q reflects the RD address during this cycle.
                state_next = WR;
                busy_next  = 1'b1;
                wren_next  = 1'b1;
                addr_next  = dst_reg + off_reg;
                data_next  = ram_q;
            end
            WR: begin
                if (last_word) begin
                    state_next = FIN;
                    done_next  = 1'b1;
                end else begin
                    state_next = RD;
                    cnt_next   = cnt_inc;
                    off_next   = off_step;
                    busy_next  = 1'b1;
                    addr_next  = src_reg + off_step;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            off_reg   <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            desc_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            addr_reg  <= '0;
            wren_reg  <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            off_reg   <= off_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            len_reg   <= len_next;
            desc_reg  <= desc_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            addr_reg  <= addr_next;
            wren_reg  <= wren_next;
            data_reg  <= data_next;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign ram_address = addr_reg;
    assign ram_wren    = wren_reg;
    assign ram_data    = data_reg;

endmodule

// File: doc/dpram_dma.md
Name: dpram_dma

Overview:
- Initiator engine that drives one port of a dual-port RAM (address/wren/data out, q in) to fill or copy RAM regions.
- Clears or patterns character/colour RAM and scrolls regions without CPU cycles.
- Sits beside the CPU, which owns the other RAM port. Software starts a job, then polls busy or waits for done.
- The RAM under control registers q on every clock from the address presented, giving a one-cycle read latency.

Parameters:
- address_width, 10, RAM address width; all address arithmetic is modulo 2**address_width.
- data_width, 8, RAM word width.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- mode  in  1  0=fill, 1=copy; sampled with start.
- src_address  in  address_width  copy source base; sampled with start.
- dst_address  in  address_width  destination base; sampled with start.
- length  in  address_width+1  word count; 0..2**address_width; sampled with start.
- fill_value  in  data_width  fill word; sampled with start.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- ram_address  out  address_width  to RAM port address.
- ram_wren  out  1  to RAM port write enable.
- ram_data  out  data_width  to RAM port write data.
- ram_q  in  data_width  from RAM port registered read data.

Behaviour:
- Interface: one clock (clock), synchronous active-high reset (reset). All outputs are registered.
- Reset: state=IDLE; busy=0, done=0, ram_wren=0, ram_address=0, ram_data=0; internal counters=0. Reset during a job aborts it immediately; no further writes occur and done does not pulse.
- States: IDLE, FILL, RD, WAIT, WR, FIN.
- IDLE, start=1 sampled at cycle 0:
  - length=0: go to FIN; no RAM writes; busy stays 0.
  - mode=0: go to FILL.
  - mode=1: go to RD.
  - Inputs are latched into internal registers; later input changes have no effect.
- FILL: each cycle drives ram_address=dst+i, ram_data=fill_value, ram_wren=1, for i=0..length-1. Writes occupy cycles 1..length. After the last write, go to FIN.
- Copy, per word i, 3 cycles:
  - RD: ram_address=src+i, ram_wren=0.
  - WAIT: address held, ram_wren=0; ram_q is valid this cycle and is captured into the data register at the cycle end.
  - WR: ram_address=dst+i, ram_data=captured word, ram_wren=1.
  - A copy of n words occupies cycles 1..3n.
- FIN: done=1 for exactly one cycle, busy=0; next state IDLE. A new start is accepted in the cycle after FIN.
- busy=1 in every FILL/RD/WAIT/WR cycle, 0 otherwise. ram_wren=1 only in FILL and WR.
- start while busy or in FIN: ignored; no queuing.
- Wrap-around: src+i and dst+i wrap modulo 2**address_width. length=2**address_width touches every location exactly once.
- Overlap without the optional feature: copy is always ascending. When dst is in (src, src+length), already-copied words are re-read (smear). This is defined, intended behaviour, used for pattern replication.
- The word counter is address_width+1 bits and counts up to the latched length.

Optional Feature:
- Macro DPRAM_DMA_OVERLAP_SAFE_EN.
- When defined:
  - Copy jobs with ((dst-src) mod 2**address_width) in 1..length-1 run descending: word order i=length-1 down to 0, addresses src+i and dst+i.
  - The result equals a memmove of the original data.
  - Fill jobs and non-overlapping copies are unchanged, including per-word timing.
- When undefined: always ascending, as above.

Test Plan:
- Fill dst=0x010, length=4, fill_value=0xA5, start at cycle 0 -> ram_wren=1 at cycles 1-4 with addresses 0x010-0x013 and data 0xA5; done=1 only at cycle 5; busy=1 at cycles 1-4.
- Copy src=0x100, dst=0x200, length=2, RAM preloaded 0x100=0x11, 0x101=0x22 -> writes 0x200=0x11 at cycle 3 and 0x201=0x22 at cycle 6; done at cycle 7; no wren at cycles 1,2,4,5.
- Wrap: fill dst=0x3FE, length=4, address_width=10 -> writes to 0x3FE, 0x3FF, 0x000, 0x001. Length 0 -> done at cycle 1, busy never 1, no writes.
- Overlap: mem[0..3]=1,2,3,4, copy src=0, dst=1, length=3:
  - macro undefined -> mem[0..3]=1,1,1,1.
  - macro defined -> mem[0..3]=1,1,2,3.
- Reset mid-job: assert reset at cycle 2 of a length-8 fill -> next cycle ram_wren=0, busy=0, done never pulses. A start during busy of another job -> ignored; the original job completes unchanged.
